// File: rtl/sys_defs.sv
// Shared processor definitions: CDB geometry and the broadcast packet layout.
package sys_defs;

    localparam int XLEN      = 32;
    localparam int NUM_CDB   = 2;
    localparam int CDB_TAG_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
    } CDB_PACKET;

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-result / CDB-broadcast bundle shared by the completion arbiter and its neighbours.
interface complete_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5
) ();
    import sys_defs::*;

    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]   fu_value;
    logic [NUM_FU-1:0]             fu_take_branch;
    logic [NUM_FU-1:0]             fu_grant;

    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value;
    logic [NUM_CDB-1:0]            cdb_take_branch;

    modport master (
        output fu_valid, fu_tag, fu_value, fu_take_branch,
        input  fu_grant, cdb_valid, cdb_tag, cdb_value, cdb_take_branch
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_take_branch,
        output fu_grant, cdb_valid, cdb_tag, cdb_value, cdb_take_branch
    );

endinterface

// File: rtl/rr_pick2.sv
// Round-robin two-winner picker: scans req from ptr upward (wrapping) and
// returns the first and second asserted requesters as one-hot grants.
module rr_pick2 #(
    parameter int NUM_FU = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_FU-1:0] gnt0,
    output logic [NUM_FU-1:0] gnt1,
    output logic              vld0,
    output logic              vld1
);

    localparam logic [PTR_W:0] NUM_FU_W = (PTR_W+1)'(NUM_FU);

    // Walk the rotated request vector; first hit fills slot 0, second fills slot 1.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        gnt0 = '0;
        gnt1 = '0;
        vld0 = 1'b0;
        vld1 = 1'b0;
        sum  = '0;
        idx  = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(off);
            if (sum >= NUM_FU_W) begin
                sum = sum - NUM_FU_W;
            end
            idx = sum[PTR_W-1:0];
            if (req[idx]) begin
                if (!vld0) begin
                    gnt0[idx] = 1'b1;
                    vld0      = 1'b1;
                end else if (!vld1) begin
                    gnt1[idx] = 1'b1;
                    vld1      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: picks up to two ready FU results per cycle round-robin,
// grants them combinationally and broadcasts them on the two CDB lanes one
// cycle later, keeping a saturating count of broadcasts.
module complete_arbiter
    import sys_defs::*;
#(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic               cdb_stall,
    complete_arbiter_if.slave  bus,
    output logic [31:0]        bcast_count
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]              r_rr_ptr;
    logic [31:0]                   r_bcast_count;
    logic [NUM_CDB-1:0]            r_cdb_valid_p1;
    logic [NUM_CDB-1:0][TAG_W-1:0] r_cdb_tag_p1;
    logic [NUM_CDB-1:0][XLEN-1:0]  r_cdb_value_p1;
    logic [NUM_CDB-1:0]            r_cdb_tb_p1;

    logic [NUM_FU-1:0]             w_gnt0;
    logic [NUM_FU-1:0]             w_gnt1;
    logic                          w_vld0;
    logic                          w_vld1;
    logic                          w_en;
    logic [NUM_CDB-1:0]            w_lane_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0] w_lane_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]  w_lane_value;
    logic [NUM_CDB-1:0]            w_lane_tb;
    logic [PTR_W-1:0]              w_last_idx;
    logic [PTR_W-1:0]              w_ptr_next;
    logic [1:0]                    w_lanes;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] n);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, n};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    rr_pick2 #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req  (bus.fu_valid),
        .ptr  (r_rr_ptr),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1),
        .vld0 (w_vld0),
        .vld1 (w_vld1)
    );

    // Reset, squash and stall all suppress granting in the request cycle.
    assign w_en         = !reset && !squash && !cdb_stall;
    assign bus.fu_grant = w_en ? (w_gnt0 | w_gnt1) : '0;

    // ---- p0: steer granted FU results onto the lanes, compute the next pointer ----
    // Lane muxes and the index of the last winner (lane 1 if used, else lane 0).
    always_comb begin
        w_lane_valid    = {w_en && w_vld1, w_en && w_vld0};
        w_lane_tag      = '0;
        w_lane_value    = '0;
        w_lane_tb       = '0;
        w_last_idx      = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_gnt0[i]) begin
                w_lane_tag[0]   = bus.fu_tag[i];
                w_lane_value[0] = bus.fu_value[i];
                w_lane_tb[0]    = bus.fu_take_branch[i];
            end
            if (w_gnt1[i]) begin
                w_lane_tag[1]   = bus.fu_tag[i];
                w_lane_value[1] = bus.fu_value[i];
                w_lane_tb[1]    = bus.fu_take_branch[i];
            end
            if (w_vld1 ? w_gnt1[i] : w_gnt0[i]) begin
                w_last_idx = PTR_W'(i);
            end
        end
        w_ptr_next = (w_last_idx == PTR_W'(NUM_FU-1)) ? '0 : w_last_idx + 1'b1;
    end

    assign w_lanes = {1'b0, r_cdb_valid_p1[0]} + {1'b0, r_cdb_valid_p1[1]};

    // ---- p1: registered CDB broadcast, round-robin pointer and broadcast counter ----
    // Idle lanes are registered as all-zero so consumers never see stale payloads.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_bcast_count  <= '0;
            r_cdb_valid_p1 <= '0;
            r_cdb_tag_p1   <= '0;
            r_cdb_value_p1 <= '0;
            r_cdb_tb_p1    <= '0;
        end else begin
            r_cdb_valid_p1 <= w_lane_valid;
            for (int l = 0; l < NUM_CDB; l++) begin
                r_cdb_tag_p1[l]   <= w_lane_valid[l] ? w_lane_tag[l]   : '0;
                r_cdb_value_p1[l] <= w_lane_valid[l] ? w_lane_value[l] : '0;
                r_cdb_tb_p1[l]    <= w_lane_valid[l] & w_lane_tb[l];
            end
            if (squash) begin
                r_rr_ptr <= '0;
            end else if (w_en && w_vld0) begin
                r_rr_ptr <= w_ptr_next;
            end
            r_bcast_count <= sat_add(r_bcast_count, w_lanes);
        end
    end

    assign bus.cdb_valid       = r_cdb_valid_p1;
    assign bus.cdb_tag         = r_cdb_tag_p1;
    assign bus.cdb_value       = r_cdb_value_p1;
    assign bus.cdb_take_branch = r_cdb_tb_p1;
    assign bcast_count         = r_bcast_count;

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed + random bench for complete_arbiter with a scoreboard of expected CDB packets.
module tb_complete_arbiter;
    import sys_defs::*;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = CDB_TAG_W;

    typedef CDB_PACKET [NUM_CDB-1:0] pair_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic        cdb_stall;
    logic [31:0] bcast_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          m_ptr  = 0;
    logic [31:0] m_count;
    int          last_lanes = 0;
    pair_t       sb_q[$];

    always #5 clock = ~clock;

    complete_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W)) bus ();

    complete_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .cdb_stall   (cdb_stall),
        .bus         (bus),
        .bcast_count (bcast_count)
    );

    function automatic logic [31:0] sat_model(input logic [31:0] a, input int n);
        longint unsigned s;
        s = longint'(a) + longint'(n);
        if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: compare the previous cycle's broadcast, then drive and predict.
    task automatic step(input logic [3:0] v, input logic st, input logic sq, input logic rs,
                        input string name);
        pair_t      e;
        pair_t      x;
        logic [3:0] eg;
        int         found;
        int         idx;
        int         last;
        @(negedge clock);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int l = 0; l < NUM_CDB; l++) begin
                check($sformatf("%s_vld%0d", name, l), 64'(bus.cdb_valid[l]), 64'(e[l].valid));
                check($sformatf("%s_tag%0d", name, l), 64'(bus.cdb_tag[l]), 64'(e[l].tag));
                check($sformatf("%s_val%0d", name, l), 64'(bus.cdb_value[l]), 64'(e[l].value));
                check($sformatf("%s_tb%0d", name, l), 64'(bus.cdb_take_branch[l]),
                      64'(e[l].take_branch));
            end
            check({name, "_cnt"}, 64'(bcast_count), 64'(m_count));
            check({name, "_ptr"}, 64'(dut.r_rr_ptr), 64'(m_ptr));
            last_lanes = int'(e[0].valid) + int'(e[1].valid);
            m_count    = sat_model(m_count, last_lanes);
        end
        bus.fu_valid = v;
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_tag[i]         = TAG_W'($urandom);
            bus.fu_value[i]       = $urandom;
            bus.fu_take_branch[i] = 1'($urandom);
        end
        cdb_stall = st;
        squash    = sq;
        reset     = rs;
        #1;
        eg    = '0;
        x     = '0;
        found = 0;
        last  = 0;
        if (!rs && !sq && !st) begin
            for (int off = 0; off < NUM_FU; off++) begin
                idx = (m_ptr + off) % NUM_FU;
                if (v[idx] && found < 2) begin
                    eg[idx]              = 1'b1;
                    x[found].valid       = 1'b1;
                    x[found].tag         = bus.fu_tag[idx];
                    x[found].value       = bus.fu_value[idx];
                    x[found].take_branch = bus.fu_take_branch[idx];
                    last                 = idx;
                    found++;
                end
            end
        end
        check({name, "_gnt"}, 64'(bus.fu_grant), 64'(eg));
        sb_q.push_back(x);
        if (rs || sq) m_ptr = 0;
        else if (found > 0) m_ptr = (last + 1) % NUM_FU;
        if (rs) m_count = '0;
    endtask

    task automatic force_count();
        force dut.r_bcast_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_bcast_count;
        m_count = sat_model(32'hFFFF_FFFE, last_lanes);
    endtask

    initial begin
        reset              = 1'b1;
        squash             = 1'b0;
        cdb_stall          = 1'b0;
        bus.fu_valid       = '0;
        bus.fu_tag         = '0;
        bus.fu_value       = '0;
        bus.fu_take_branch = '0;

        step(4'b0000, 1'b0, 1'b0, 1'b1, "rst0");
        step(4'b1111, 1'b0, 1'b0, 1'b1, "rst1");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "idle");
        step(4'b1011, 1'b0, 1'b0, 1'b0, "basic");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "single");
        step(4'b1001, 1'b0, 1'b0, 1'b0, "wrap");
        step(4'b1111, 1'b0, 1'b1, 1'b0, "squash");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "all_a");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "all_b");
        step(4'b0100, 1'b1, 1'b0, 1'b0, "stall");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "unstall");
        step(4'b0111, 1'b0, 1'b0, 1'b0, "three");
        step(4'b0100, 1'b0, 1'b0, 1'b0, "retry");
        step(4'b1111, 1'b1, 1'b1, 1'b0, "sq_stall");
        for (int k = 0; k < 40; k++) begin
            step(4'($urandom), ($urandom % 5) == 0, ($urandom % 8) == 0, 1'b0, "rand");
        end
        step(4'b0000, 1'b0, 1'b0, 1'b0, "pre_sat");
        force_count();
        step(4'b1111, 1'b0, 1'b0, 1'b0, "sat1");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "sat2");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "sat3");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "sat_idle");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "sat_end");
        step(4'b1111, 1'b0, 1'b0, 1'b0, "mid");
        step(4'b1111, 1'b1, 1'b1, 1'b1, "mid_rst");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "post1");
        step(4'b0000, 1'b0, 1'b0, 1'b0, "post2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
